lcd_bus_receiver: RTL and testbench

- Receiving end of the 4-bit character-LCD bus that MiniAlu drives (Enabled, RegisterSelect, ReadWrite, StrataFlashControl, Data[3:0]).
- Decodes E pulses into nibbles, tracks the power-up init sequence, and reassembles high/low nibble pairs into command/data bytes.
- Checks pulse width and inter-pulse gap timing against parameters.
- Used as a synthesizable bus checker beside MiniAlu and as the LCD model in TestBench.

---
 rtl/lcd_rx_pkg.sv | 26 ++
 rtl/lcd_rx_pulse_meter.sv | 89 ++++++++
 rtl/lcd_bus_receiver.sv | 243 ++++++++++++++++++++++++
 tb/tb_lcd_bus_receiver.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_rx_pkg.sv
// Shared definitions for the 4-bit character-LCD bus receiver:
// FSM state encodings, sticky error bit positions, init nibble constants
// and a helper that builds a one-hot error mask.
package lcd_rx_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } rx_state_e;

    localparam int unsigned ERR_SHORT_E     = 32'd0;
    localparam int unsigned ERR_GAP         = 32'd1;
    localparam int unsigned ERR_RS_MISMATCH = 32'd2;
    localparam int unsigned ERR_INIT        = 32'd3;

    localparam logic [3:0] INIT_NIB_A   = 4'h3;
    localparam logic [3:0] INIT_NIB_B   = 4'h2;
    localparam logic [1:0] INIT_REPEATS = 2'd3;

    // One-hot mask for a sticky error bit position.
    function automatic logic [3:0] err_bit(input int unsigned idx);
        err_bit = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/lcd_rx_pulse_meter.sv
// Front end of the LCD receiver: registers the bus once, detects E edges,
// measures E-high width and E-low gap. The gap counter holds while E is
// high, so at the fall it still reports the gap that preceded the rise.
module lcd_rx_pulse_meter
    import lcd_rx_pkg::*;
#(
    parameter int MIN_E_CYCLES = 12,
    parameter int CNT_W        = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             e,
    input  logic             rs,
    input  logic             rw,
    input  logic             sf,
    input  logic [3:0]       data,
    output logic             fall,
    output logic             owned,
    output logic             nib_rs,
    output logic [3:0]       nib_data,
    output logic             width_ok,
    output logic [CNT_W-1:0] gap_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] MIN_E   = CNT_W'(MIN_E_CYCLES);

    logic             e_r;
    logic             rs_r;
    logic             rw_r;
    logic             sf_r;
    logic [3:0]       data_r;
    logic [CNT_W-1:0] width_cnt_r;
    logic [CNT_W-1:0] gap_cnt_r;
    logic             rise;

    assign rise     = !e_r && e;
    assign fall     = e_r && !e;
    assign owned    = !rw_r && sf_r;
    assign nib_rs   = rs_r;
    assign nib_data = data_r;
    assign width_ok = (width_cnt_r >= MIN_E);
    assign gap_cnt  = gap_cnt_r;

    // Single register stage on every bus input; these hold the E-high values at the fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_r    <= 1'b0;
            rs_r   <= 1'b0;
            rw_r   <= 1'b0;
            sf_r   <= 1'b0;
            data_r <= 4'h0;
        end else begin
            e_r    <= e;
            rs_r   <= rs;
            rw_r   <= rw;
            sf_r   <= sf;
            data_r <= data;
        end
    end

    // Count E-high cycles, starting at one on the rise, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width_cnt_r <= {CNT_W{1'b0}};
        end else if (rise) begin
            width_cnt_r <= CNT_ONE;
        end else if (e && (width_cnt_r != CNT_MAX)) begin
            width_cnt_r <= width_cnt_r + CNT_ONE;
        end else begin
            width_cnt_r <= width_cnt_r;
        end
    end

    // Count E-low cycles since the last owned fall; starts saturated so the first pulse passes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt_r <= CNT_MAX;
        end else if (fall && owned) begin
            gap_cnt_r <= CNT_ONE;
        end else if (!e && (gap_cnt_r != CNT_MAX)) begin
            gap_cnt_r <= gap_cnt_r + CNT_ONE;
        end else begin
            gap_cnt_r <= gap_cnt_r;
        end
    end

endmodule

// File: rtl/lcd_bus_receiver.sv
// Receiver / checker for the 4-bit LCD bus: tracks the 3,3,3,2 power-up
// sequence, pairs high/low nibbles into bytes and flags timing/protocol
// errors in sticky bits.
// Optional macro LCD_RX_FIFO_EN: bytes go through a 4-entry FIFO with
// iReady back-pressure; otherwise oValid is a one-cycle pulse.
module lcd_bus_receiver
    import lcd_rx_pkg::*;
#(
    parameter int MIN_E_CYCLES   = 12,
    parameter int MIN_NIBBLE_GAP = 50,
    parameter int MIN_BYTE_GAP   = 2000,
    parameter int CNT_W          = 12
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iLCD_Enabled,
    input  logic       iLCD_RegisterSelect,
    input  logic       iLCD_ReadWrite,
    input  logic       iLCD_StrataFlashControl,
    input  logic [3:0] iLCD_Data,
    input  logic       iErrClear,
    input  logic       iReady,
    output logic [7:0] oByte,
    output logic       oIsData,
    output logic       oValid,
    output logic       oInitDone,
    output logic [3:0] oError
);

    localparam logic [CNT_W-1:0] GAP_NIB  = CNT_W'(MIN_NIBBLE_GAP);
    localparam logic [CNT_W-1:0] GAP_BYTE = CNT_W'(MIN_BYTE_GAP);

    logic             fall;
    logic             owned;
    logic             nib_rs;
    logic [3:0]       nib_data;
    logic             width_ok;
    logic [CNT_W-1:0] gap_cnt;

    rx_state_e   state_r, state_nx;
    logic [1:0]  init_cnt_r, init_cnt_nx;
    logic [3:0]  hi_r, hi_nx;
    logic        hi_rs_r, hi_rs_nx;
    logic        init_done_r;
    logic        init_set;
    logic [3:0]  err_r;
    logic [3:0]  err_set;
    logic [3:0]  ovf_err;
    logic        byte_done;
    logic [7:0]  byte_val;
    logic [CNT_W-1:0] gap_min;

    lcd_rx_pulse_meter #(
        .MIN_E_CYCLES (MIN_E_CYCLES),
        .CNT_W        (CNT_W)
    ) u_meter (
        .clk      (Clock),
        .rst      (Reset),
        .e        (iLCD_Enabled),
        .rs       (iLCD_RegisterSelect),
        .rw       (iLCD_ReadWrite),
        .sf       (iLCD_StrataFlashControl),
        .data     (iLCD_Data),
        .fall     (fall),
        .owned    (owned),
        .nib_rs   (nib_rs),
        .nib_data (nib_data),
        .width_ok (width_ok),
        .gap_cnt  (gap_cnt)
    );

    // FSM state, init counter and latched high nibble.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r     <= INIT;
            init_cnt_r  <= 2'd0;
            hi_r        <= 4'h0;
            hi_rs_r     <= 1'b0;
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_nx;
            init_cnt_r  <= init_cnt_nx;
            hi_r        <= hi_nx;
            hi_rs_r     <= hi_rs_nx;
            init_done_r <= init_done_r | init_set;
        end
    end

    // Next state, error events and byte completion on each owned E fall.
    always_comb begin
        state_nx    = state_r;
        init_cnt_nx = init_cnt_r;
        hi_nx       = hi_r;
        hi_rs_nx    = hi_rs_r;
        init_set    = 1'b0;
        err_set     = 4'b0000;
        byte_done   = 1'b0;
        byte_val    = {hi_r, nib_data};
        gap_min     = (state_r == LOW) ? GAP_NIB : GAP_BYTE;
        if (fall && owned) begin
            if (gap_cnt < gap_min) begin
                err_set = err_set | err_bit(ERR_GAP);
            end else begin
                err_set = err_set;
            end
            if (!width_ok) begin
                err_set = err_set | err_bit(ERR_SHORT_E);
            end else begin
                case (state_r)
                    INIT: begin
                        if (!nib_rs && (nib_data == INIT_NIB_A)) begin
                            if (init_cnt_r != INIT_REPEATS) begin
                                init_cnt_nx = init_cnt_r + 2'd1;
                            end else begin
                                init_cnt_nx = init_cnt_r;
                            end
                        end else if (!nib_rs && (nib_data == INIT_NIB_B) &&
                                     (init_cnt_r == INIT_REPEATS)) begin
                            state_nx = HIGH;
                            init_set = 1'b1;
                        end else begin
                            err_set     = err_set | err_bit(ERR_INIT);
                            init_cnt_nx = 2'd0;
                        end
                    end
                    HIGH: begin
                        hi_nx    = nib_data;
                        hi_rs_nx = nib_rs;
                        state_nx = LOW;
                    end
                    LOW: begin
                        state_nx = HIGH;
                        if (nib_rs == hi_rs_r) begin
                            byte_done = 1'b1;
                        end else begin
                            err_set = err_set | err_bit(ERR_RS_MISMATCH);
                        end
                    end
                    default: begin
                        state_nx = INIT;
                    end
                endcase
            end
        end else begin
            state_nx = state_r;
        end
    end

    // Sticky error bits; a same-cycle event beats the clear.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            err_r <= 4'b0000;
        end else if (iErrClear) begin
            err_r <= err_set | ovf_err;
        end else begin
            err_r <= err_r | err_set | ovf_err;
        end
    end

    assign oError    = err_r;
    assign oInitDone = init_done_r;

`ifdef LCD_RX_FIFO_EN
    logic [8:0] fifo_mem [0:3];
    logic [1:0] wr_ptr_r;
    logic [1:0] rd_ptr_r;
    logic [2:0] count_r;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       push;

    assign fifo_full  = (count_r == 3'd4);
    assign fifo_empty = (count_r == 3'd0);
    assign pop        = !fifo_empty && iReady;
    assign push       = byte_done && (!fifo_full || pop);
    assign ovf_err    = (byte_done && fifo_full && !pop) ? err_bit(ERR_GAP) : 4'b0000;

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem[i] <= 9'h000;
            end
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            count_r  <= 3'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_r] <= {nib_rs, byte_val};
                wr_ptr_r           <= wr_ptr_r + 2'd1;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign oValid  = !fifo_empty;
    assign oByte   = fifo_mem[rd_ptr_r][7:0];
    assign oIsData = fifo_mem[rd_ptr_r][8];
`else
    logic       ready_unused;
    logic [7:0] byte_r;
    logic       is_data_r;
    logic       valid_r;

    assign ready_unused = iReady;
    assign ovf_err      = 4'b0000;

    // One-cycle valid pulse; byte and RS hold until the next completed byte.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            byte_r    <= 8'h00;
            is_data_r <= 1'b0;
            valid_r   <= 1'b0;
        end else begin
            valid_r <= byte_done;
            if (byte_done) begin
                byte_r    <= byte_val;
                is_data_r <= nib_rs;
            end else begin
                byte_r    <= byte_r;
                is_data_r <= is_data_r;
            end
        end
    end

    assign oValid  = valid_r;
    assign oByte   = byte_r;
    assign oIsData = is_data_r;
`endif

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver: stimulus pushes expected bytes into
// a scoreboard queue, a negedge monitor pops and compares on every handshake.
module tb_lcd_bus_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       e;
    logic       rs;
    logic       rw;
    logic       sf;
    logic [3:0] data;
    logic       err_clr;
    logic       ready;
    logic [7:0] o_byte;
    logic       o_is_data;
    logic       o_valid;
    logic       o_init_done;
    logic [3:0] o_error;

    typedef struct {
        logic [7:0] b;
        logic       d;
        int         at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_x;
    int   cyc = 0;
    int   last_end = 0;
    int   checks = 0;
    int   failures = 0;

    lcd_bus_receiver dut (
        .Clock                   (clk),
        .Reset                   (rst),
        .iLCD_Enabled            (e),
        .iLCD_RegisterSelect     (rs),
        .iLCD_ReadWrite          (rw),
        .iLCD_StrataFlashControl (sf),
        .iLCD_Data               (data),
        .iErrClear               (err_clr),
        .iReady                  (ready),
        .oByte                   (o_byte),
        .oIsData                 (o_is_data),
        .oValid                  (o_valid),
        .oInitDone               (o_init_done),
        .oError                  (o_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every accepted output byte must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (o_valid === 1'b1) && ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=%0h required=none", o_byte);
            end else begin
                mon_x = sb.pop_front();
                check("byte", {24'h0, o_byte}, {24'h0, mon_x.b});
                check("is_data", {31'h0, o_is_data}, {31'h0, mon_x.d});
                if (mon_x.at != 0) check("latency", cyc, mon_x.at);
            end
        end
    end

    // One E pulse; gap counts low clocks since the last owned fall.
    task automatic pulse(input int gap, input int width, input logic p_rs, input logic [3:0] p_d,
                         input logic p_rw, input logic p_sf);
        while (cyc < last_end + gap) begin
            @(posedge clk);
            #1;
        end
        rs   = p_rs;
        rw   = p_rw;
        sf   = p_sf;
        data = p_d;
        e    = 1'b1;
        repeat (width) @(posedge clk);
        #1;
        e = 1'b0;
        if (!p_rw && p_sf) last_end = cyc;
    endtask

    task automatic after_fall();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_byte(input logic p_rs, input logic [7:0] b, input int gap_lo,
                             input logic expect_out, input logic timed);
        exp_t x;
        pulse(2000, 12, p_rs, b[7:4], 1'b0, 1'b1);
        pulse(gap_lo, 12, p_rs, b[3:0], 1'b0, 1'b1);
        if (expect_out) begin
            x.b  = b;
            x.d  = p_rs;
            x.at = timed ? cyc + 1 : 0;
            sb.push_back(x);
        end
        after_fall();
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        check("err_cleared", {28'h0, o_error}, 32'h0);
    endtask

    task automatic init_seq(input int threes);
        for (int i = 0; i < threes; i++) pulse(2000, 12, 1'b0, 4'h3, 1'b0, 1'b1);
        pulse(2000, 12, 1'b0, 4'h2, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; e = 1'b0; rs = 1'b0; rw = 1'b0; sf = 1'b1; data = 4'h0;
        err_clr = 1'b0; ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        last_end = cyc - 2000;
        @(negedge clk);
        check("rst_byte", {24'h0, o_byte}, 32'h0);
        check("rst_is_data", {31'h0, o_is_data}, 32'h0);
        check("rst_valid", {31'h0, o_valid}, 32'h0);
        check("rst_init_done", {31'h0, o_init_done}, 32'h0);
        check("rst_error", {28'h0, o_error}, 32'h0);

        // Power-up sequence 3,3,3,2
        init_seq(3);
        @(negedge clk);
        check("init_done_pre_fall", {31'h0, o_init_done}, 32'h0);
        @(negedge clk);
        check("init_done", {31'h0, o_init_done}, 32'h1);
        check("init_err", {28'h0, o_error}, 32'h0);

        // Data byte 0x41 with minimum legal nibble gap
        send_byte(1'b1, 8'h41, 50, 1'b1, 1'b1);
        check("err_after_41", {28'h0, o_error}, 32'h0);
        repeat (3) @(negedge clk);
        check("hold_valid", {31'h0, o_valid}, 32'h0);
        check("hold_byte", {24'h0, o_byte}, 32'h41);
        check("hold_is_data", {31'h0, o_is_data}, 32'h1);

        // Short E pulse on the high nibble, then command 0x01
        pulse(2000, 11, 1'b0, 4'h0, 1'b0, 1'b1);
        after_fall();
        check("short_err", {28'h0, o_error}, 32'h1);
        send_byte(1'b0, 8'h01, 50, 1'b1, 1'b1);
        check("short_sticky", {28'h0, o_error}, 32'h1);
        clear_err();

        // Nibble gap one short of the minimum; byte still delivered
        send_byte(1'b0, 8'h28, 49, 1'b1, 1'b1);
        check("gap_err", {28'h0, o_error}, 32'h2);
        clear_err();

        // RS mismatch between nibbles
        pulse(2000, 12, 1'b1, 4'h4, 1'b0, 1'b1);
        pulse(50, 12, 1'b0, 4'h1, 1'b0, 1'b1);
        after_fall();
        check("rs_err", {28'h0, o_error}, 32'h4);
        clear_err();

        // Read pulse and unowned pulse: ignored, no error, gap not restarted
        pulse(100, 5, 1'b0, 4'h7, 1'b1, 1'b1);
        pulse(300, 5, 1'b0, 4'h7, 1'b0, 1'b0);
        after_fall();
        check("ignored_err", {28'h0, o_error}, 32'h0);
        pulse(2100, 12, 1'b1, 4'h5, 1'b0, 1'b1);
        pulse(50, 12, 1'b1, 4'h5, 1'b0, 1'b1);
        begin
            exp_t x;
            x.b = 8'h55; x.d = 1'b1; x.at = cyc + 1;
            sb.push_back(x);
        end
        after_fall();
        check("ignored_gap_err", {28'h0, o_error}, 32'h0);

        // Reset between the nibbles of 0x41
        pulse(2000, 12, 1'b1, 4'h4, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_byte", {24'h0, o_byte}, 32'h0);
        check("midrst_is_data", {31'h0, o_is_data}, 32'h0);
        check("midrst_valid", {31'h0, o_valid}, 32'h0);
        check("midrst_init_done", {31'h0, o_init_done}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_end = cyc - 2000;
        pulse(2, 12, 1'b1, 4'h1, 1'b0, 1'b1);
        after_fall();
        check("midrst_state_init", {28'h0, o_error}, 32'h8);
        clear_err();

        // Incomplete init 3,3,2
        init_seq(2);
        after_fall();
        check("bad_init_err", {28'h0, o_error}, 32'h8);
        check("bad_init_done", {31'h0, o_init_done}, 32'h0);
        clear_err();

        // Init with an extra 3 (counter saturates) recovers
        init_seq(4);
        after_fall();
        check("reinit_done", {31'h0, o_init_done}, 32'h1);
        check("reinit_err", {28'h0, o_error}, 32'h0);

`ifdef LCD_RX_FIFO_EN
        // Back-pressure: five bytes into a four-entry FIFO
        #1 ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send_byte(1'b1, 8'hA0 + 8'(k), 50, (k < 4), 1'b0);
        end
        check("fifo_valid_held", {31'h0, o_valid}, 32'h1);
        check("fifo_head", {24'h0, o_byte}, 32'hA0);
        check("fifo_ovf_err", {28'h0, o_error}, 32'h2);
        #1 ready = 1'b1;
        repeat (8) @(negedge clk);
        check("fifo_drained", {31'h0, o_valid}, 32'h0);
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
